scatter_tile_db: RTL

SCATTER_TILE_DB -- requirements
Module: scatter_tile_db

---
 rtl/scatter_pkg.sv | 27 ++
 rtl/scatter_tile_db_tile_buf.sv | 43 ++++
 rtl/scatter_tile_db.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scatter_pkg.sv
// rtl/scatter_pkg.sv - shared fetch-state encoding and geometry helpers for scatter_tile_db
package scatter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_WAIT_BUF = 3'd3,
        ST_DONE     = 3'd4
    } fetch_state_e;

    // BRAM words that make up one tile row
    function automatic int calc_wpr(input int n, input int w, input int bram_w);
        return (n * w) / bram_w;
    endfunction

    // BRAM words that make up one full matrix row
    function automatic int calc_row_words(input int mat_x, input int w, input int bram_w);
        return (mat_x * w) / bram_w;
    endfunction

    // number of N x N tiles in the matrix
    function automatic int calc_tiles(input int mat_x, input int mat_y, input int n);
        return (mat_x / n) * (mat_y / n);
    endfunction

endpackage

// File: rtl/scatter_tile_db_tile_buf.sv
// rtl/scatter_tile_db_tile_buf.sv - one N x N tile store, word-granular row write, row or column read
module tile_buf #(
    parameter int W      = 8,
    parameter int N      = 16,
    parameter int BRAM_W = 128,
    parameter int WPR    = 1,
    parameter int RW     = 4,
    parameter int WCW    = 1
) (
    input  logic                      clk,
    input  logic                      wr_en_i,
    input  logic [RW-1:0]             wr_row_i,
    input  logic [WCW-1:0]            wr_word_i,
    input  logic [BRAM_W-1:0]         wr_data_i,
    input  logic [RW-1:0]             rd_idx_i,
    input  logic                      transpose_i,
    output logic [N-1:0][W-1:0]       rd_data_o
);

    localparam int LPW = BRAM_W / W;

    logic [N-1:0][W-1:0] mem_q [N];
    logic [N-1:0][W-1:0] row_new;

    // merge the incoming BRAM word into its lane slot of the addressed row
    for (genvar k = 0; k < WPR; k++) begin : g_word
        assign row_new[k*LPW +: LPW] = (wr_word_i == WCW'(k)) ? wr_data_i
                                                              : mem_q[wr_row_i][k*LPW +: LPW];
    end

    // row write; contents need no reset because fullness is tracked outside
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= row_new;
        end
    end

    // lane j is element (idx, j) in row mode or element (j, idx) in column mode
    for (genvar j = 0; j < N; j++) begin : g_lane
        assign rd_data_o[j] = transpose_i ? mem_q[j][rd_idx_i] : mem_q[rd_idx_i][j];
    end

endmodule

// File: rtl/scatter_tile_db.sv
// rtl/scatter_tile_db.sv - double-buffered BRAM-to-tile scatter engine; SCATTER_DEBUG_EN adds debug ports
module scatter_tile_db
    import scatter_pkg::*;
#(
    parameter int W       = 8,
    parameter int N       = 16,
    parameter int BRAM_W  = 128,
    parameter int BRAM_AW = 10,
    parameter int MAT_X   = 64,
    parameter int MAT_Y   = 64,
    parameter int RD_LAT  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BRAM_AW-1:0]     base_addr,
    input  logic                   transpose,
    output logic                   bram_clk_b,
    output logic                   bram_we_b,
    output logic [BRAM_AW-1:0]     bram_addr_b,
    output logic [BRAM_W-1:0]      bram_wrdata_b,
    input  logic [BRAM_W-1:0]      bram_rddata_b,
    output logic [N-1:0][W-1:0]    b_ins,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic                   stationaryCtrl,
    output logic                   busy,
    output logic                   load_done
`ifdef SCATTER_DEBUG_EN
    ,
    output logic [2:0]                                     debug_state,
    output logic [$clog2(calc_tiles(MAT_X, MAT_Y, N)):0]   debug_tile_cnt,
    output logic [$clog2(N)-1:0]                           debug_row_cnt,
    output logic [1:0]                                     debug_buf_full
`endif
);

    localparam int WPR       = calc_wpr(N, W, BRAM_W);
    localparam int ROW_WORDS = calc_row_words(MAT_X, W, BRAM_W);
    localparam int T         = calc_tiles(MAT_X, MAT_Y, N);
    localparam int TX        = MAT_X / N;
    localparam int RW        = $clog2(N);
    localparam int WCW       = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int TCW       = $clog2(T) + 1;
    localparam int TXW       = (TX > 1) ? $clog2(TX) : 1;
    localparam int TYW       = ((MAT_Y / N) > 1) ? $clog2(MAT_Y / N) : 1;
    localparam int EW        = 2 + RW + WCW;

    fetch_state_e         state_q, state_d;
    logic [TCW-1:0]       tile_q, tile_d;
    logic [TXW-1:0]       tc_q, tc_d;
    logic [TYW-1:0]       tr_q, tr_d;
    logic [RW-1:0]        row_q, row_d;
    logic [WCW-1:0]       word_q, word_d;
    logic                 flush_q, flush_d;
    logic                 fill_sel_q, fill_sel_d;
    logic [BRAM_AW-1:0]   base_q, base_d;
    logic                 transpose_q, transpose_d;
    logic                 load_done_q, load_done_d;

    logic [1:0]           full_q, full_d;
    logic                 nxt_sel_q, nxt_sel_d;
    logic [RW-1:0]        nxt_beat_q, nxt_beat_d;
    logic                 out_sel_q, out_sel_d;
    logic [RW-1:0]        out_beat_q, out_beat_d;
    logic                 b_valid_q, b_valid_d;
    logic                 stat_q, stat_d;
    logic [N-1:0][W-1:0]  b_ins_q, b_ins_d;

    logic                 issue;
    logic                 out_fire;
    logic [BRAM_AW-1:0]   addr_calc;
    logic [EW-1:0]        pipe0_q;
    logic [EW-1:0]        cap;
    logic                 cap_vld, cap_sel, cap_last;
    logic [RW-1:0]        cap_row;
    logic [WCW-1:0]       cap_word;
    logic [N-1:0][W-1:0]  rd_data [2];

    assign issue    = (state_q == ST_FETCH);
    assign out_fire = b_valid_q & b_ready;

    // wide arithmetic truncated to BRAM_AW gives the required modulo wrap
    assign addr_calc = base_q + BRAM_AW'((32'(tr_q) * N + 32'(row_q)) * ROW_WORDS
                                         + 32'(tc_q) * WPR + 32'(word_q));

    assign bram_clk_b    = clk;
    assign bram_we_b     = 1'b0;
    assign bram_wrdata_b = '0;
    assign bram_addr_b   = issue ? addr_calc : '0;

    // fetch FSM next state: walk N*WPR addresses, drain the read pipe, then hop buffers
    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        tc_d        = tc_q;
        tr_d        = tr_q;
        row_d       = row_q;
        word_d      = word_q;
        flush_d     = flush_q;
        fill_sel_d  = fill_sel_q;
        base_d      = base_q;
        transpose_d = transpose_q;
        load_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    base_d      = base_addr;
                    transpose_d = transpose;
                    tile_d      = '0;
                    tc_d        = '0;
                    tr_d        = '0;
                    row_d       = '0;
                    word_d      = '0;
                    fill_sel_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (word_q == WCW'(WPR - 1)) begin
                    word_d = '0;
                    row_d  = row_q + 1'b1;
                end else begin
                    word_d = word_q + 1'b1;
                end
                if (row_q == RW'(N - 1) && word_q == WCW'(WPR - 1)) begin
                    state_d = ST_FLUSH;
                    row_d   = '0;
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_q == 1'(RD_LAT - 1)) begin
                    if (tile_q == TCW'(T - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        tile_d     = tile_q + 1'b1;
                        fill_sel_d = ~fill_sel_q;
                        if (tc_q == TXW'(TX - 1)) begin
                            tc_d = '0;
                            tr_d = tr_q + 1'b1;
                        end else begin
                            tc_d = tc_q + 1'b1;
                        end
                        state_d = full_q[~fill_sel_q] ? ST_WAIT_BUF : ST_FETCH;
                    end
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            ST_WAIT_BUF: begin
                if (!full_q[fill_sel_q]) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                if (full_q == 2'b00) begin
                    state_d     = ST_IDLE;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // fetch-side state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tile_q      <= '0;
            tc_q        <= '0;
            tr_q        <= '0;
            row_q       <= '0;
            word_q      <= '0;
            flush_q     <= 1'b0;
            fill_sel_q  <= 1'b0;
            base_q      <= '0;
            transpose_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            tc_q        <= tc_d;
            tr_q        <= tr_d;
            row_q       <= row_d;
            word_q      <= word_d;
            flush_q     <= flush_d;
            fill_sel_q  <= fill_sel_d;
            base_q      <= base_d;
            transpose_q <= transpose_d;
            load_done_q <= load_done_d;
        end
    end

    // first stage of the read-return tag pipe; reset drops in-flight words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe0_q <= '0;
        end else begin
            pipe0_q <= {issue, fill_sel_q, row_q, word_q};
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [EW-1:0] pipe1_q;
        // second tag stage for two-cycle BRAM reads
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe1_q <= '0;
            end else begin
                pipe1_q <= pipe0_q;
            end
        end
        assign cap = pipe1_q;
    end else begin : g_lat1
        assign cap = pipe0_q;
    end

    assign cap_vld  = cap[EW-1];
    assign cap_sel  = cap[EW-2];
    assign cap_row  = cap[EW-3 -: RW];
    assign cap_word = cap[WCW-1:0];
    assign cap_last = (cap_row == RW'(N - 1)) && (cap_word == WCW'(WPR - 1));

    for (genvar b = 0; b < 2; b++) begin : g_buf
        tile_buf #(
            .W      (W),
            .N      (N),
            .BRAM_W (BRAM_W),
            .WPR    (WPR),
            .RW     (RW),
            .WCW    (WCW)
        ) u_tile_buf (
            .clk         (clk),
            .wr_en_i     (cap_vld && (cap_sel == 1'(b))),
            .wr_row_i    (cap_row),
            .wr_word_i   (cap_word),
            .wr_data_i   (bram_rddata_b),
            .rd_idx_i    (nxt_beat_q),
            .transpose_i (transpose_q),
            .rd_data_o   (rd_data[b])
        );
    end

    // drain side: track buffer fullness and advance the output register when it is free
    always_comb begin
        full_d     = full_q;
        nxt_sel_d  = nxt_sel_q;
        nxt_beat_d = nxt_beat_q;
        out_sel_d  = out_sel_q;
        out_beat_d = out_beat_q;
        b_valid_d  = b_valid_q;
        stat_d     = stat_q;
        b_ins_d    = b_ins_q;
        if (out_fire && out_beat_q == RW'(N - 1)) begin
            full_d[out_sel_q] = 1'b0;
        end
        if (cap_vld && cap_last) begin
            full_d[cap_sel] = 1'b1;
        end
        if (!b_valid_q || out_fire) begin
            if (full_q[nxt_sel_q]) begin
                b_valid_d  = 1'b1;
                b_ins_d    = rd_data[nxt_sel_q];
                stat_d     = (nxt_beat_q == '0);
                out_sel_d  = nxt_sel_q;
                out_beat_d = nxt_beat_q;
                if (nxt_beat_q == RW'(N - 1)) begin
                    nxt_beat_d = '0;
                    nxt_sel_d  = ~nxt_sel_q;
                end else begin
                    nxt_beat_d = nxt_beat_q + 1'b1;
                end
            end else begin
                b_valid_d = 1'b0;
                stat_d    = 1'b0;
            end
        end
        if (state_q == ST_IDLE && start) begin
            nxt_sel_d  = 1'b0;
            nxt_beat_d = '0;
        end
    end

    // drain-side registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q     <= 2'b00;
            nxt_sel_q  <= 1'b0;
            nxt_beat_q <= '0;
            out_sel_q  <= 1'b0;
            out_beat_q <= '0;
            b_valid_q  <= 1'b0;
            stat_q     <= 1'b0;
            b_ins_q    <= '0;
        end else begin
            full_q     <= full_d;
            nxt_sel_q  <= nxt_sel_d;
            nxt_beat_q <= nxt_beat_d;
            out_sel_q  <= out_sel_d;
            out_beat_q <= out_beat_d;
            b_valid_q  <= b_valid_d;
            stat_q     <= stat_d;
            b_ins_q    <= b_ins_d;
        end
    end

    assign b_ins          = b_ins_q;
    assign b_valid        = b_valid_q;
    assign stationaryCtrl = stat_q;
    assign busy           = (state_q != ST_IDLE);
    assign load_done      = load_done_q;

`ifdef SCATTER_DEBUG_EN
    assign debug_state    = state_q;
    assign debug_tile_cnt = tile_q;
    assign debug_row_cnt  = row_q;
    assign debug_buf_full = full_q;
`endif

endmodule
